picomem_arb_2_1: RTL

//  Two-master to one-slave PicoMem arbiter: shares one PicoMem slave port (SRAM or
//  the peripheral sub-mux) between the CPU (m0) and a second bus master (m1, e.g. DMA).

---
 rtl/picomem_pkg.sv | 16 +
 rtl/picomem_rr_pick.sv | 25 ++
 rtl/picomem_arb_2_1.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/picomem_pkg.sv
// Shared PicoMem definitions: bus widths, arbiter state encoding and the
// default read data returned when an access is forcibly completed.
package picomem_pkg;

  localparam int PICO_AW = 32;
  localparam int PICO_DW = 32;
  localparam int PICO_SW = 4;

  localparam logic [PICO_DW-1:0] PICO_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pico_state_e;

endpackage

// File: rtl/picomem_rr_pick.sv
// Combinational 2-way picker: round-robin on last owner, or fixed priority to m0.
module picomem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_mode,
  output logic [1:0] win
);

  // last = 1 means m1 owned the previous grant, so m0 wins a tie
  always_comb begin
    win = 2'b00;
    if (prio_mode) begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end else begin
      case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = last ? 2'b01 : 2'b10;
        default: win = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/picomem_arb_2_1.sv
// Two-master to one-slave PicoMem arbiter with registered grant, one transaction
// per grant. Define PICOMEM_ARB_TIMEOUT_EN to add the BUSY timeout counter.
module picomem_arb_2_1
  import picomem_pkg::*;
#(
  parameter int                 PRIO_MODE      = 0,
  parameter int                 TIMEOUT_CYCLES = 1024,
  parameter logic [PICO_DW-1:0] ERR_RDATA      = PICO_ERR_RDATA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_valid,
  input  logic [PICO_AW-1:0] m0_addr,
  input  logic [PICO_DW-1:0] m0_wdata,
  input  logic [PICO_SW-1:0] m0_wstrb,
  output logic               m0_ready,
  output logic [PICO_DW-1:0] m0_rdata,
  input  logic               m1_valid,
  input  logic [PICO_AW-1:0] m1_addr,
  input  logic [PICO_DW-1:0] m1_wdata,
  input  logic [PICO_SW-1:0] m1_wstrb,
  output logic               m1_ready,
  output logic [PICO_DW-1:0] m1_rdata,
  output logic               s_valid,
  output logic [PICO_AW-1:0] s_addr,
  output logic [PICO_DW-1:0] s_wdata,
  output logic [PICO_SW-1:0] s_wstrb,
  input  logic               s_ready,
  input  logic [PICO_DW-1:0] s_rdata,
  output logic [1:0]         grant,
  output logic               timeout_flag
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("picomem_arb_2_1: TIMEOUT_CYCLES must be at least 2");
  end

  pico_state_e state_p1, state_d;
  logic [1:0]  grant_p1, grant_d;
  logic        last_p1, last_d;
  logic [1:0]  win;
  logic        busy, owner_valid, timeout_hit, done_ok, done_to, done;
  logic [PICO_DW-1:0] cpl_rdata;

  picomem_rr_pick u_pick (
    .req       ({m1_valid, m0_valid}),
    .last      (last_p1),
    .prio_mode (PRIO_MODE != 0),
    .win       (win)
  );

  assign busy        = (state_p1 == ST_BUSY);
  assign owner_valid = (grant_p1[0] & m0_valid) | (grant_p1[1] & m1_valid);
  assign s_valid     = busy & owner_valid;
  assign grant       = grant_p1;

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (busy && grant_p1[0]) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (busy && grant_p1[1]) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

`ifdef PICOMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_p1;
  logic             tflag_p1;

  // Counter idles at zero, so it is already cleared on the first BUSY cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_p1 <= '0;
    else if (!busy) cnt_p1 <= '0;
    else            cnt_p1 <= cnt_p1 + 1'b1;
  end

  assign timeout_hit = busy && (cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tflag_p1 <= 1'b0;
    else if (done_to) tflag_p1 <= 1'b1;
  end

  assign timeout_flag = tflag_p1;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // A real slave completion on the timeout cycle wins over the forced one
  assign done_ok   = s_valid & s_ready;
  assign done_to   = s_valid & ~s_ready & timeout_hit;
  assign done      = done_ok | done_to;
  assign cpl_rdata = done_to ? ERR_RDATA : s_rdata;

  assign m0_ready = done & grant_p1[0];
  assign m1_ready = done & grant_p1[1];
  assign m0_rdata = m0_ready ? cpl_rdata : '0;
  assign m1_rdata = m1_ready ? cpl_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= ST_IDLE;
      grant_p1 <= 2'b00;
      last_p1  <= 1'b1;
    end else begin
      state_p1 <= state_d;
      grant_p1 <= grant_d;
      last_p1  <= last_d;
    end
  end

  // An owner abandoning its request is dropped without updating fairness
  always_comb begin
    state_d = state_p1;
    grant_d = grant_p1;
    last_d  = last_p1;
    case (state_p1)
      ST_IDLE: begin
        if (win != 2'b00) begin
          state_d = ST_BUSY;
          grant_d = win;
        end
      end
      ST_BUSY: begin
        if (!owner_valid) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else if (done) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = grant_p1[1];
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

endmodule
